mm_stream_master: RTL

Stream-side initiator for the 4x4 matrix-multiply accelerator. It holds operand matrices A and B in local registers loaded through a simple write port. On start it emits them over an AXI-Stream master port in the exact word order the multiplier consumes, and captures the 16 result words from an AXI-Stream slave port into a readable C buffer. It sits between the DMA/config side and the multiplier, and replaces software-driven streaming in block-level and SoC tests.

---
 rtl/mm_stream_if.sv | 37 +++
 rtl/mm_stream_master.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mm_stream_if.sv
// mm_stream_if
//   Operand and result AXI-Stream channels between mm_stream_master and the
//   4x4 matrix multiplier.
//   sm_tvalid / sm_tdata / sm_tready : operand words, master -> multiplier
//   ss_tvalid / ss_tdata / ss_tready : result words, multiplier -> master
//   modport master : mm_stream_master side
//   modport slave  : multiplier side
interface mm_stream_if #(
    parameter int pDATA_WIDTH = 32
) ();

    logic                   sm_tvalid;
    logic [pDATA_WIDTH-1:0] sm_tdata;
    logic                   sm_tready;
    logic                   ss_tvalid;
    logic [pDATA_WIDTH-1:0] ss_tdata;
    logic                   ss_tready;

    modport master (
        output sm_tvalid,
        output sm_tdata,
        input  sm_tready,
        input  ss_tvalid,
        input  ss_tdata,
        output ss_tready
    );

    modport slave (
        input  sm_tvalid,
        input  sm_tdata,
        output sm_tready,
        output ss_tvalid,
        output ss_tdata,
        input  ss_tready
    );

endinterface

// File: rtl/mm_stream_master.sv
// mm_stream_master
//   Stream-side initiator for the 4x4 matrix-multiply accelerator. Holds the
//   A and B operand matrices, streams them to the multiplier in the order it
//   consumes them, and captures the 16 result words into a readable C buffer.
//   Ports:
//     axis_clk, axis_rst_n : clock, asynchronous active-low reset
//     start                : one-cycle run request (accepted in IDLE/DONE)
//     busy, done           : run in progress / one-cycle completion pulse
//     cfg_we/addr/wdata    : operand write port (0-15 = A, 16-31 = B)
//     rd_addr, rd_data     : registered C read port, one-cycle latency
//     mm_start_whole       : one-cycle kick to the multiplier
//     axis                 : operand (sm_*) and result (ss_*) streams
//   Stream order: A row 0, then per column j: B column j and one result
//   C[0][j]; then per row i = 1..3: A row i and four results C[i][0..3].
module mm_stream_master #(
    parameter int pDATA_WIDTH = 32
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    input  logic                   cfg_we,
    input  logic [4:0]             cfg_addr,
    input  logic [pDATA_WIDTH-1:0] cfg_wdata,
    input  logic [3:0]             rd_addr,
    output logic [pDATA_WIDTH-1:0] rd_data,
    output logic                   mm_start_whole,
    mm_stream_if.master            axis
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_KICK     = 3'd1,
        ST_SEND_A0  = 3'd2,
        ST_SEND_B   = 3'd3,
        ST_RECV_C0  = 3'd4,
        ST_SEND_A   = 3'd5,
        ST_RECV_ROW = 3'd6,
        ST_DONE     = 3'd7
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;

    // k = word within a phase, j = B column, i = A row
    logic [1:0]             k_r;
    logic [1:0]             j_r;
    logic [1:0]             i_r;
    logic [1:0]             k_nxt_s;
    logic [1:0]             j_nxt_s;
    logic [1:0]             i_nxt_s;

    // Matrices stored row-major: element [r][c] lives at index 4r+c
    logic [pDATA_WIDTH-1:0] a_r [16];
    logic [pDATA_WIDTH-1:0] b_r [16];
    logic [pDATA_WIDTH-1:0] c_r [16];

    logic                   sm_tvalid_r;
    logic [pDATA_WIDTH-1:0] sm_tdata_r;
    logic                   ss_tready_r;
    logic                   busy_r;
    logic                   done_r;
    logic                   kick_r;
    logic [pDATA_WIDTH-1:0] rd_data_r;

    logic                   sm_tvalid_nxt_s;
    logic [pDATA_WIDTH-1:0] sm_tdata_nxt_s;
    logic                   ss_tready_nxt_s;
    logic                   busy_nxt_s;
    logic                   done_nxt_s;
    logic                   kick_nxt_s;

    logic                   sm_hs_s;
    logic                   ss_hs_s;
    logic                   cfg_ok_s;
    logic [3:0]             c_idx_s;

    assign sm_hs_s  = sm_tvalid_r & axis.sm_tready;
    assign ss_hs_s  = ss_tready_r & axis.ss_tvalid;
    assign cfg_ok_s = cfg_we & ~busy_r;

    assign axis.sm_tvalid = sm_tvalid_r;
    assign axis.sm_tdata  = sm_tdata_r;
    assign axis.ss_tready = ss_tready_r;
    assign busy           = busy_r;
    assign done           = done_r;
    assign mm_start_whole = kick_r;
    assign rd_data        = rd_data_r;

    // State register, phase counters and registered control outputs
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state_r     <= ST_IDLE;
            k_r         <= 2'd0;
            j_r         <= 2'd0;
            i_r         <= 2'd0;
            sm_tvalid_r <= 1'b0;
            sm_tdata_r  <= {pDATA_WIDTH{1'b0}};
            ss_tready_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            kick_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            k_r         <= k_nxt_s;
            j_r         <= j_nxt_s;
            i_r         <= i_nxt_s;
            sm_tvalid_r <= sm_tvalid_nxt_s;
            sm_tdata_r  <= sm_tdata_nxt_s;
            ss_tready_r <= ss_tready_nxt_s;
            busy_r      <= busy_nxt_s;
            done_r      <= done_nxt_s;
            kick_r      <= kick_nxt_s;
        end
    end

    // Next-state logic: phases end on the 4th handshake (1st for RECV_C0)
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt_s = ST_KICK;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_KICK: begin
                state_nxt_s = ST_SEND_A0;
            end
            ST_SEND_A0: begin
                if (sm_hs_s && (k_r == 2'd3)) begin
                    state_nxt_s = ST_SEND_B;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_SEND_B: begin
                if (sm_hs_s && (k_r == 2'd3)) begin
                    state_nxt_s = ST_RECV_C0;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_RECV_C0: begin
                if (ss_hs_s) begin
                    if (j_r == 2'd3) begin
                        state_nxt_s = ST_SEND_A;
                    end else begin
                        state_nxt_s = ST_SEND_B;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_SEND_A: begin
                if (sm_hs_s && (k_r == 2'd3)) begin
                    state_nxt_s = ST_RECV_ROW;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_RECV_ROW: begin
                if (ss_hs_s && (k_r == 2'd3)) begin
                    if (i_r == 2'd3) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_SEND_A;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Counter next values; k wraps naturally to 0 after the 4th word
    always_comb begin
        k_nxt_s = k_r;
        j_nxt_s = j_r;
        i_nxt_s = i_r;
        case (state_r)
            ST_KICK: begin
                k_nxt_s = 2'd0;
                j_nxt_s = 2'd0;
                i_nxt_s = 2'd0;
            end
            ST_SEND_A0, ST_SEND_B, ST_SEND_A: begin
                if (sm_hs_s) begin
                    k_nxt_s = k_r + 2'd1;
                end else begin
                    k_nxt_s = k_r;
                end
            end
            ST_RECV_C0: begin
                if (ss_hs_s) begin
                    j_nxt_s = j_r + 2'd1;
                    if (j_r == 2'd3) begin
                        i_nxt_s = 2'd1;
                    end else begin
                        i_nxt_s = i_r;
                    end
                end else begin
                    j_nxt_s = j_r;
                    i_nxt_s = i_r;
                end
            end
            ST_RECV_ROW: begin
                if (ss_hs_s) begin
                    k_nxt_s = k_r + 2'd1;
                    if (k_r == 2'd3) begin
                        i_nxt_s = i_r + 2'd1;
                    end else begin
                        i_nxt_s = i_r;
                    end
                end else begin
                    k_nxt_s = k_r;
                    i_nxt_s = i_r;
                end
            end
            default: begin
                k_nxt_s = k_r;
                j_nxt_s = j_r;
                i_nxt_s = i_r;
            end
        endcase
    end

    // Output logic: next values of the registered outputs, looked ahead from
    // the next state and next counters so every output is a flop
    always_comb begin
        sm_tvalid_nxt_s = 1'b0;
        sm_tdata_nxt_s  = sm_tdata_r;
        ss_tready_nxt_s = 1'b0;
        busy_nxt_s      = 1'b1;
        done_nxt_s      = 1'b0;
        kick_nxt_s      = 1'b0;
        c_idx_s         = {i_r, k_r};

        // A handshake on the last word of a phase forces one idle cycle on
        // the operand stream, even when the next phase is also a send phase
        case (state_nxt_s)
            ST_SEND_A0: begin
                sm_tvalid_nxt_s = ~(sm_hs_s & (k_r == 2'd3));
                sm_tdata_nxt_s  = a_r[{2'b00, k_nxt_s}];
            end
            ST_SEND_B: begin
                sm_tvalid_nxt_s = ~(sm_hs_s & (k_r == 2'd3));
                sm_tdata_nxt_s  = b_r[{k_nxt_s, j_nxt_s}];
            end
            ST_SEND_A: begin
                sm_tvalid_nxt_s = ~(sm_hs_s & (k_r == 2'd3));
                sm_tdata_nxt_s  = a_r[{i_nxt_s, k_nxt_s}];
            end
            ST_RECV_C0, ST_RECV_ROW: begin
                ss_tready_nxt_s = 1'b1;
            end
            ST_KICK: begin
                kick_nxt_s = 1'b1;
            end
            ST_IDLE: begin
                busy_nxt_s = 1'b0;
            end
            ST_DONE: begin
                busy_nxt_s = 1'b0;
                done_nxt_s = (state_r != ST_DONE);
            end
            default: begin
                sm_tvalid_nxt_s = 1'b0;
            end
        endcase

        // Row 0 results arrive one per column; later rows arrive as a block
        if (state_r == ST_RECV_C0) begin
            c_idx_s = {2'b00, j_r};
        end else begin
            c_idx_s = {i_r, k_r};
        end
    end

    // Operand write port, result capture and C read port
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            for (int n = 0; n < 16; n++) begin
                a_r[n] <= {pDATA_WIDTH{1'b0}};
                b_r[n] <= {pDATA_WIDTH{1'b0}};
                c_r[n] <= {pDATA_WIDTH{1'b0}};
            end
            rd_data_r <= {pDATA_WIDTH{1'b0}};
        end else begin
            if (cfg_ok_s) begin
                if (cfg_addr[4]) begin
                    b_r[cfg_addr[3:0]] <= cfg_wdata;
                end else begin
                    a_r[cfg_addr[3:0]] <= cfg_wdata;
                end
            end
            if (ss_hs_s) begin
                c_r[c_idx_s] <= axis.ss_tdata;
            end
            rd_data_r <= c_r[rd_addr];
        end
    end

endmodule
